alu_muldiv: RTL and testbench

Parametrised execute-stage integer unit, successor to the single-cycle combinational ALU. It adds a registered valid/ready handshake, a configurable data width, and iterative RV-M multiply/divide. Base ALU ops complete in one cycle; multiply/divide run a shift-add or restoring-division loop of XLEN iterations. The unit sits between issue and writeback in the execute stage and carries an opaque tag so writeback can route results.

---
 rtl/alu_muldiv_if.sv | 50 +++++
 rtl/alu_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Function codes and the issue/writeback handshake bundle for the execute-stage integer unit.
package alu_muldiv_pkg;
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_fun_t;
endpackage

interface alu_muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic                        in_valid;
    logic                        in_ready;
    alu_muldiv_pkg::alu_fun_t    in_fun;
    logic [1:0][XLEN-1:0]        in_ops;
    logic [TAG_W-1:0]            in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_opd;
    logic [TAG_W-1:0]            out_tag;

    // Issue side drives operations and consumes results.
    modport master (
        output in_valid, in_fun, in_ops, in_tag, out_ready,
        input  in_ready, out_valid, out_opd, out_tag
    );

    // The execute unit.
    modport slave (
        input  in_valid, in_fun, in_ops, in_tag, out_ready,
        output in_ready, out_valid, out_opd, out_tag
    );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage integer unit: single-cycle base ALU plus iterative RV-M
// multiply (shift-add) and divide (restoring), one iteration per clock.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    alu_muldiv_if.slave io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    alu_fun_t         fun_q;
    logic             div_q;
    logic             neg_q;
    logic [TAG_W-1:0] tag_q;
    // acc: product high half / partial remainder
    // lo : multiplier shifting out / quotient shifting in
    // opb: multiplicand / divisor (magnitudes)
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  opb;
    logic [XLEN-1:0]  opd_q;
    logic [TAG_W-1:0] otag_q;

    logic             rdy;
    logic             accept;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [SHW-1:0]   shamt;
    logic             is_md;
    logic             is_div;
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic             early;
    logic             neg_in;
    logic [XLEN-1:0]  quick;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_rs;
    logic [XLEN:0]    div_sub;
    logic             div_ge;
    logic [XLEN-1:0]  acc_nx;
    logic [XLEN-1:0]  lo_nx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  md_res;

    assign rdy    = (state == S_IDLE) || (state == S_DONE && io.out_ready);
    assign accept = io.in_valid && rdy;

    assign io.in_ready  = rdy;
    assign io.out_valid = (state == S_DONE);
    assign io.out_opd   = opd_q;
    assign io.out_tag   = otag_q;

    assign op_a  = io.in_ops[0];
    assign op_b  = io.in_ops[1];
    assign shamt = op_b[SHW-1:0];

    // Decode mul/div class and operand signedness.
    always_comb begin
        is_md  = 1'b0;
        is_div = 1'b0;
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        case (io.in_fun)
            ALU_MUL, ALU_MULH: begin is_md = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            ALU_MULHSU:        begin is_md = 1'b1; a_sgn = 1'b1; end
            ALU_MULHU:         begin is_md = 1'b1; end
            ALU_DIV, ALU_REM:  begin is_md = 1'b1; is_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            ALU_DIVU, ALU_REMU: begin is_md = 1'b1; is_div = 1'b1; end
            default: ;
        endcase
    end

    assign a_neg  = a_sgn & op_a[XLEN-1];
    assign b_neg  = b_sgn & op_b[XLEN-1];
    assign abs_a  = a_neg ? (~op_a + 1'b1) : op_a;
    assign abs_b  = b_neg ? (~op_b + 1'b1) : op_b;
    // Remainder follows the dividend; quotient and product follow the sign product.
    assign neg_in = (io.in_fun == ALU_REM) ? a_neg : (a_neg ^ b_neg);
    // Divide by zero and MIN/-1 have fixed answers and skip the loop.
    assign early  = is_div && ((op_b == '0) || (a_sgn && op_a == MIN_VAL && op_b == '1));

    // Single-cycle results: base ALU, divide early-outs, and the unknown-fun marker.
    always_comb begin
        quick = {(XLEN/32){32'hdeadbeef}};
        case (io.in_fun)
            ALU_ADD:  quick = op_a + op_b;
            ALU_SUB:  quick = op_a - op_b;
            ALU_AND:  quick = op_a & op_b;
            ALU_OR:   quick = op_a | op_b;
            ALU_XOR:  quick = op_a ^ op_b;
            ALU_SLT:  quick = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: quick = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:  quick = op_a << shamt;
            ALU_SRL:  quick = op_a >> shamt;
            ALU_SRA:  quick = $signed(op_a) >>> shamt;
            ALU_DIV, ALU_DIVU: quick = (op_b == '0) ? '1 : MIN_VAL;
            ALU_REM, ALU_REMU: quick = (op_b == '0) ? op_a : '0;
            default: ;
        endcase
    end

    // One loop iteration, plus the sign fix-up applied to its outcome on the last pass.
    always_comb begin
        mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        div_rs  = {acc, lo[XLEN-1]};
        div_sub = div_rs - {1'b0, opb};
        div_ge  = (div_rs >= {1'b0, opb});
        if (div_q) begin
            acc_nx = div_ge ? div_sub[XLEN-1:0] : div_rs[XLEN-1:0];
            lo_nx  = {lo[XLEN-2:0], div_ge};
        end else begin
            acc_nx = mul_sum[XLEN:1];
            lo_nx  = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod = neg_q ? -{acc_nx, lo_nx} : {acc_nx, lo_nx};
        case (fun_q)
            ALU_MULH, ALU_MULHSU, ALU_MULHU: md_res = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU: md_res = neg_q ? -lo_nx : lo_nx;
            ALU_REM, ALU_REMU: md_res = neg_q ? -acc_nx : acc_nx;
            default:           md_res = prod[XLEN-1:0];
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            fun_q  <= ALU_ADD;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            tag_q  <= '0;
            acc    <= '0;
            lo     <= '0;
            opb    <= '0;
            opd_q  <= '0;
            otag_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_BUSY: begin
                    acc <= acc_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1)) begin
                        opd_q  <= md_res;
                        otag_q <= tag_q;
                        cnt    <= '0;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_md && !early) begin
                            fun_q <= io.in_fun;
                            div_q <= is_div;
                            neg_q <= neg_in;
                            tag_q <= io.in_tag;
                            acc   <= '0;
                            lo    <= is_div ? abs_a : abs_b;
                            opb   <= is_div ? abs_b : abs_a;
                            cnt   <= '0;
                            state <= S_BUSY;
                        end else begin
                            opd_q  <= quick;
                            otag_q <= io.in_tag;
                            state  <= S_DONE;
                        end
                    end else if (state != S_DONE || io.out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: table of single operations plus hand-written
// streaming, backpressure, flush and reset sequences.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic clock;
    logic reset;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    alu_muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

    alu_muldiv #(.XLEN(32), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .io    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        alu_fun_t    fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(alu_fun_t f, logic [31:0] a, logic [31:0] b,
                                logic [4:0] t, logic [31:0] e, int l);
        vec_t v;
        v.fun = f; v.a = a; v.b = b; v.tag = t; v.exp = e; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one op from IDLE with out_ready=1; report result, tag and edges to out_valid.
    task automatic run_op(input alu_fun_t f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] o, output logic [4:0] ot,
                          output int lat);
        bus.in_fun    = f;
        bus.in_ops[0] = a;
        bus.in_ops[1] = b;
        bus.in_tag    = t;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        o  = bus.out_opd;
        ot = bus.out_tag;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] o;
        logic [4:0]  ot;
        int          lat;
        int          bad;
        logic        rose;

        vecs.push_back(mk(ALU_ADD,    32'hFFFFFFFF, 32'h00000001, 5'd3,  32'h00000000, 1));
        vecs.push_back(mk(ALU_SUB,    32'h00000005, 32'h00000007, 5'd1,  32'hFFFFFFFE, 1));
        vecs.push_back(mk(ALU_AND,    32'hF0F0F0F0, 32'hFF00FF00, 5'd2,  32'hF000F000, 1));
        vecs.push_back(mk(ALU_OR,     32'hF0F0F0F0, 32'hFF00FF00, 5'd4,  32'hFFF0FFF0, 1));
        vecs.push_back(mk(ALU_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 5'd5,  32'h0FF00FF0, 1));
        vecs.push_back(mk(ALU_SLT,    32'hFFFFFFFF, 32'h00000001, 5'd6,  32'h00000001, 1));
        vecs.push_back(mk(ALU_SLTU,   32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000000, 1));
        vecs.push_back(mk(ALU_SLL,    32'h00000001, 32'h00000024, 5'd8,  32'h00000010, 1));
        vecs.push_back(mk(ALU_SRL,    32'h80000000, 32'h0000001F, 5'd9,  32'h00000001, 1));
        vecs.push_back(mk(ALU_SRA,    32'h80000000, 32'h00000021, 5'd10, 32'hC0000000, 1));
        vecs.push_back(mk(alu_fun_t'(5'd12), 32'h1, 32'h2,      5'd11, 32'hDEADBEEF, 1));
        vecs.push_back(mk(ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000001, 33));
        vecs.push_back(mk(ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h00000000, 33));
        vecs.push_back(mk(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFE, 33));
        vecs.push_back(mk(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(ALU_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd16, 32'hFFFFFFEB, 33));
        vecs.push_back(mk(ALU_MULH,   32'h80000000, 32'h80000000, 5'd17, 32'h40000000, 33));
        vecs.push_back(mk(ALU_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd18, 32'hFFFFFFFD, 33));
        vecs.push_back(mk(ALU_REM,    32'hFFFFFFF9, 32'h00000002, 5'd19, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(ALU_DIV,    32'h00000007, 32'hFFFFFFFE, 5'd20, 32'hFFFFFFFD, 33));
        vecs.push_back(mk(ALU_REM,    32'h00000007, 32'hFFFFFFFE, 5'd21, 32'h00000001, 33));
        vecs.push_back(mk(ALU_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 5'd22, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(ALU_DIVU,   32'd100,      32'd7,        5'd23, 32'd14,       33));
        vecs.push_back(mk(ALU_REMU,   32'd100,      32'd7,        5'd24, 32'd2,        33));
        vecs.push_back(mk(ALU_DIVU,   32'h00000007, 32'h00000000, 5'd25, 32'hFFFFFFFF, 1));
        vecs.push_back(mk(ALU_REMU,   32'h00000007, 32'h00000000, 5'd26, 32'h00000007, 1));
        vecs.push_back(mk(ALU_REM,    32'h80000000, 32'hFFFFFFFF, 5'd27, 32'h00000000, 1));
        vecs.push_back(mk(ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd28, 32'h80000000, 1));

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_fun    = ALU_ADD;
        bus.in_ops    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        check("reset out_valid", bus.out_valid, 0);
        check("reset out_opd",   bus.out_opd,   0);
        check("reset out_tag",   bus.out_tag,   0);
        check("reset in_ready",  bus.in_ready,  1);

        foreach (vecs[i]) begin
            run_op(vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].tag, o, ot, lat);
            check($sformatf("vec%0d opd", i), o,   vecs[i].exp);
            check($sformatf("vec%0d tag", i), ot,  vecs[i].tag);
            check($sformatf("vec%0d lat", i), lat, vecs[i].lat);
        end

        // Stream of 8 ADDs, one per clock, with a 5-cycle stall after the fourth result.
        bus.out_ready = 1'b1;
        bus.in_fun    = ALU_ADD;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_ops[0] = 32'(k * 3);
            bus.in_ops[1] = 32'd100;
            bus.in_tag    = 5'(k);
            tick();
            check($sformatf("stream%0d valid", k), bus.out_valid, 1);
            check($sformatf("stream%0d opd", k),   bus.out_opd,   32'(k * 3 + 100));
            check($sformatf("stream%0d tag", k),   bus.out_tag,   5'(k));
            if (k == 3) begin
                bus.out_ready = 1'b0;
                bus.in_ops[0] = 32'd12;
                bus.in_tag    = 5'd4;
                bad = 0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    if (bus.in_ready) bad++;
                    tick();
                    if (!bus.out_valid || bus.out_opd !== 32'd109 || bus.out_tag !== 5'd3) bad++;
                end
                check("stall hold", bad, 0);
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream drain idle", bus.out_valid, 0);

        // DIVU flushed on its tenth BUSY cycle.
        bus.in_fun    = ALU_DIVU;
        bus.in_ops[0] = 32'd1000;
        bus.in_ops[1] = 32'd3;
        bus.in_tag    = 5'd9;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bad = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.in_ready || bus.out_valid) bad++;
            tick();
        end
        check("busy in_ready low", bad, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush in_ready", bus.in_ready, 1);
        check("flush out_valid", bus.out_valid, 0);
        rose = 1'b0;
        repeat (40) begin
            tick();
            if (bus.out_valid) rose = 1'b1;
        end
        check("flush never valid", rose, 0);

        // Flush in the same cycle as an accept discards the op.
        bus.in_fun    = ALU_ADD;
        bus.in_ops[0] = 32'd1;
        bus.in_ops[1] = 32'd1;
        bus.in_tag    = 5'd1;
        bus.in_valid  = 1'b1;
        flush         = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush beats accept", bus.out_valid, 0);

        run_op(ALU_ADD, 32'd2, 32'd3, 5'd4, o, ot, lat);
        check("post-flush add opd", o, 32'd5);
        check("post-flush add tag", ot, 5'd4);
        check("post-flush add lat", lat, 1);

        // Reset while holding a result under backpressure.
        bus.out_ready = 1'b0;
        bus.in_fun    = ALU_ADD;
        bus.in_ops[0] = 32'd9;
        bus.in_ops[1] = 32'd9;
        bus.in_tag    = 5'd7;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("held valid", bus.out_valid, 1);
        check("held opd", bus.out_opd, 32'd18);
        repeat (2) tick();
        check("held opd later", bus.out_opd, 32'd18);
        check("held in_ready", bus.in_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset out_valid", bus.out_valid, 0);
        check("mid reset out_opd",   bus.out_opd,   0);
        check("mid reset out_tag",   bus.out_tag,   0);
        check("mid reset in_ready",  bus.in_ready,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
